// File: rtl/nco_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nco_ctrl_pkg                                                 |
// | Description : Shared types and default widths for the NCO sweep controller |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package nco_ctrl_pkg;

    localparam int C_TW_WIDTH_DEF    = 32;
    localparam int C_DWELL_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DWELL   = 2'd1,
        ADVANCE = 2'd2
    } state_t;

    // Encoding 3 is reserved and decodes as SINGLE.
    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        REPEAT = 2'd1,
        UPDOWN = 2'd2
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/axis_sweep_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_sweep_ctrl_if                                           |
// | Description : AXI-Stream tuning-word channel towards the NCO               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface axis_sweep_ctrl_if
    import nco_ctrl_pkg::*;
#(
    parameter int TW_WIDTH = C_TW_WIDTH_DEF
) ();

    logic [TW_WIDTH-1:0] tdata;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/axis_sweep_dwell_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_sweep_dwell_cnt                                         |
// | Description : Loadable dwell down-counter with zero flag                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module axis_sweep_dwell_cnt #(
    parameter int WIDTH = 16
) (
    input  wire              aclk,
    input  wire              arst,
    input  wire              i_load,
    input  wire [WIDTH-1:0]  i_load_val,
    input  wire              i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // Saturates at zero so a stray enable cannot wrap the count.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/axis_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_sweep_ctrl                                              |
// | Description : Frequency-sweep sequencer driving NCO tuning words           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module axis_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int TW_WIDTH    = C_TW_WIDTH_DEF,
    parameter int DWELL_WIDTH = C_DWELL_WIDTH_DEF
) (
    input  wire                    aclk,
    input  wire                    arst,
    input  wire [TW_WIDTH-1:0]     cfg_start_tw,
    input  wire [TW_WIDTH-1:0]     cfg_stop_tw,
    input  wire [TW_WIDTH-1:0]     cfg_step_tw,
    input  wire [DWELL_WIDTH-1:0]  cfg_dwell,
    input  wire [1:0]              cfg_mode,
    input  wire                    start,
    input  wire                    abort,
    axis_sweep_ctrl_if.master      m_axis_tw,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            step_idx
);

    state_t                 r_state, w_state_nxt;
    logic                   r_dir, w_dir_nxt;          // 1 = sweeping down
    logic [TW_WIDTH-1:0]    r_tdata, w_tdata_nxt;
    logic                   r_tvalid, w_tvalid_nxt;
    logic                   r_done, w_done_nxt;
    logic [15:0]            r_step_idx, w_step_idx_nxt;

    logic [TW_WIDTH-1:0]    r_sh_start, r_sh_stop, r_sh_step;
    logic [DWELL_WIDTH-1:0] r_sh_dwell;
    logic [1:0]             r_sh_mode;

    logic                   w_latch, w_emit;
    logic [TW_WIDTH-1:0]    w_emit_tw;
    logic                   w_cnt_load, w_cnt_en, w_cnt_zero;
    logic [DWELL_WIDTH-1:0] w_cnt_load_val, w_cfg_dwell_m1, w_sh_dwell_m1;
    logic [TW_WIDTH:0]      w_up_sum, w_dn_diff;
    logic                   w_up_ok, w_dn_ok;

    // Counter holds "beats remaining after this one", so dwell 0 and 1 coincide.
    assign w_cfg_dwell_m1 = (cfg_dwell  == '0) ? '0 : cfg_dwell  - DWELL_WIDTH'(1);
    assign w_sh_dwell_m1  = (r_sh_dwell == '0) ? '0 : r_sh_dwell - DWELL_WIDTH'(1);

    assign w_up_sum  = {1'b0, r_tdata} + {1'b0, r_sh_step};
    assign w_dn_diff = {1'b0, r_tdata} - {1'b0, r_sh_step};
    assign w_up_ok   = !w_up_sum[TW_WIDTH]  && (w_up_sum[TW_WIDTH-1:0]  <= r_sh_stop);
    assign w_dn_ok   = !w_dn_diff[TW_WIDTH] && (w_dn_diff[TW_WIDTH-1:0] >= r_sh_start);

    axis_sweep_dwell_cnt #(
        .WIDTH      (DWELL_WIDTH)
    ) u_dwell_cnt (
        .aclk       (aclk),
        .arst       (arst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_dir_nxt      = r_dir;
        w_tdata_nxt    = r_tdata;
        w_tvalid_nxt   = r_tvalid;
        w_done_nxt     = 1'b0;
        w_step_idx_nxt = r_step_idx;
        w_latch        = 1'b0;
        w_emit         = 1'b0;
        w_emit_tw      = r_tdata;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = w_sh_dwell_m1;
        w_cnt_en       = 1'b0;

        if (abort) begin
            w_state_nxt  = IDLE;
            w_tdata_nxt  = '0;
            w_tvalid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_latch        = 1'b1;
                        w_tdata_nxt    = cfg_start_tw;
                        w_tvalid_nxt   = 1'b1;
                        w_step_idx_nxt = '0;
                        w_dir_nxt      = 1'b0;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = w_cfg_dwell_m1;
                        w_state_nxt    = DWELL;
                    end
                end
                DWELL: begin
                    if (r_tvalid && m_axis_tw.tready) begin
                        if (w_cnt_zero) begin
                            w_state_nxt = ADVANCE;
                        end else begin
                            w_cnt_en = 1'b1;
                        end
                    end
                end
                ADVANCE: begin
                    if (!r_dir && w_up_ok) begin
                        w_emit    = 1'b1;
                        w_emit_tw = w_up_sum[TW_WIDTH-1:0];
                    end else if (r_dir || (r_sh_mode == UPDOWN)) begin
                        // Down leg, or up-down turning round at the top.
                        w_emit = 1'b1;
                        if (w_dn_ok) begin
                            w_dir_nxt = 1'b1;
                            w_emit_tw = w_dn_diff[TW_WIDTH-1:0];
                        end else begin
                            w_dir_nxt = 1'b0;
                            w_emit_tw = w_up_ok ? w_up_sum[TW_WIDTH-1:0] : r_tdata;
                        end
                    end else if (r_sh_mode == REPEAT) begin
                        w_emit    = 1'b1;
                        w_emit_tw = r_sh_start;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_tdata_nxt  = '0;
                        w_tvalid_nxt = 1'b0;
                        w_done_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_tdata_nxt  = '0;
                    w_tvalid_nxt = 1'b0;
                end
            endcase
        end

        if (w_emit) begin
            w_state_nxt = DWELL;
            w_tdata_nxt = w_emit_tw;
            w_cnt_load  = 1'b1;
            if (w_emit_tw != r_tdata) begin
                w_step_idx_nxt = r_step_idx + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state    <= IDLE;
            r_dir      <= 1'b0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_done     <= 1'b0;
            r_step_idx <= '0;
            r_sh_start <= '0;
            r_sh_stop  <= '0;
            r_sh_step  <= '0;
            r_sh_dwell <= '0;
            r_sh_mode  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_tdata    <= w_tdata_nxt;
            r_tvalid   <= w_tvalid_nxt;
            r_done     <= w_done_nxt;
            r_step_idx <= w_step_idx_nxt;
            if (w_latch) begin
                r_sh_start <= cfg_start_tw;
                r_sh_stop  <= cfg_stop_tw;
                r_sh_step  <= cfg_step_tw;
                r_sh_dwell <= cfg_dwell;
                r_sh_mode  <= cfg_mode;
            end
        end
    end

    assign m_axis_tw.tdata  = r_tdata;
    assign m_axis_tw.tvalid = r_tvalid;
    assign busy             = (r_state != IDLE);
    assign done             = r_done;
    assign step_idx         = r_step_idx;

endmodule
`default_nettype wire
